// File: rtl/bram_1kb_access_driver.sv
// Fabric-side request/response driver for the 1 KB block RAM primitive.
// Registers all RAM address/data pins, tracks read latency and returns zero-extended reads in order.
module bram_1kb_access_driver #(
    parameter int RD_ADDR_MSB_LSB = 24,
    parameter int WR_ADDR_MSB_LSB = 16,
    parameter int WE_BIT          = 20,
    parameter int REG_OUT         = 0,
    parameter int RSP_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cfg_wr_width,
    input  logic [1:0]  cfg_rd_width,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [9:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic [7:0]  bram_rd_addr,
    output logic [7:0]  bram_wr_addr,
    output logic [31:0] bram_wr_data,
    input  logic [31:0] bram_rd_data,
    output logic        bram_c0,
    output logic        bram_c1,
    output logic        bram_c2,
    output logic        bram_c3,
    output logic        bram_c4,
    output logic        bram_c5
);

    localparam int LAT = 2 + REG_OUT;
    localparam int PW  = $clog2(RSP_DEPTH);
    localparam int CW  = PW + 1;
    localparam int SW  = PW + 2;
    localparam logic [SW-1:0] DEPTH_L = SW'(RSP_DEPTH);

    logic                  wr8_s;
    logic [1:0]            rd_mode_s;
    logic [1:0]            wsel_s;
    logic [1:0]            rsel_s;
    logic [31:0]           wr_word_s;
    logic [31:0]           rd_word_s;
    logic [SW-1:0]         inflight_s;
    logic [SW-1:0]         occupancy_s;
    logic                  ready_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  push_s;
    logic                  pop_s;
    logic [LAT-1:0]        tag_r;
    logic [LAT-1:0][1:0]   wid_r;
    logic [31:0]           mem_r [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [7:0]            rd_addr_r;
    logic [7:0]            wr_addr_r;
    logic [31:0]           wr_data_r;

    // The RAM passes raw upper bits on narrow reads, so mask them here.
    function automatic logic [31:0] zext(input logic [31:0] d, input logic [1:0] mode);
        case (mode)
            2'd2:    return {24'd0, d[7:0]};
            2'd1:    return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Width decode and per-request address/side-band packing.
    always_comb begin
        wr8_s = (cfg_wr_width == 2'd1);
        case (cfg_rd_width)
            2'd1:    rd_mode_s = 2'd1;
            2'd2:    rd_mode_s = 2'd2;
            default: rd_mode_s = 2'd0;
        endcase
        wsel_s = wr8_s ? req_addr[9:8] : {1'b0, req_addr[8]};
        case (rd_mode_s)
            2'd2:    rsel_s = req_addr[9:8];
            2'd1:    rsel_s = {1'b0, req_addr[8]};
            default: rsel_s = 2'd0;
        endcase
        wr_word_s        = 32'd0;
        wr_word_s[15:0]  = wr8_s ? {8'd0, req_wdata[7:0]} : req_wdata;
        wr_word_s[WR_ADDR_MSB_LSB +: 2] = wsel_s;
        wr_word_s[WE_BIT] = 1'b1;
        rd_word_s        = 32'd0;
        rd_word_s[RD_ADDR_MSB_LSB +: 2] = rsel_s;
    end

    // Credits: every read in the pipe already owns a FIFO slot.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_s = inflight_s + SW'(tag_r[i]);
        end
        occupancy_s = SW'(count_r) + inflight_s;
    end

    assign ready_s   = (occupancy_s < DEPTH_L);
    assign wr_acc_s  = req_valid & ready_s & req_we;
    assign rd_acc_s  = req_valid & ready_s & ~req_we;
    assign push_s    = tag_r[LAT-1];
    assign pop_s     = rsp_valid & rsp_ready;

    assign req_ready = ready_s;
    assign rsp_valid = (count_r != '0);
    assign rsp_rdata = rsp_valid ? mem_r[rd_ptr_r] : 32'd0;
    assign busy      = rsp_valid | (inflight_s != '0);

    assign bram_rd_addr = rd_addr_r;
    assign bram_wr_addr = wr_addr_r;
    assign bram_wr_data = wr_data_r;
    assign bram_c0 = wr8_s;
    assign bram_c1 = ~wr8_s;
    assign bram_c2 = rd_mode_s[1];
    assign bram_c3 = rd_mode_s[0];
    assign bram_c4 = 1'b0;
    assign bram_c5 = (REG_OUT != 0);

    // RAM pin registers; the write strobe lives for exactly one presented cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_r <= 8'd0;
            wr_addr_r <= 8'd0;
            wr_data_r <= 32'd0;
        end else if (wr_acc_s) begin
            wr_addr_r <= req_addr[7:0];
            wr_data_r <= wr_word_s;
        end else if (rd_acc_s) begin
            rd_addr_r <= req_addr[7:0];
            wr_data_r <= rd_word_s;
        end else begin
            wr_data_r <= 32'd0;
        end
    end

    // Read-slot tags with their width, aligned to the cycle the RAM data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_r <= '0;
            wid_r <= '0;
        end else begin
            tag_r <= {tag_r[LAT-2:0], rd_acc_s};
            wid_r <= {wid_r[LAT-2:0], rd_mode_s};
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= zext(bram_rd_data, wid_r[LAT-1]);
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_1kb_access_driver.sv
// Bench for bram_1kb_access_driver: RAM behavioural model, flat byte-memory scoreboard
// compared every cycle, plus directed literal checks; a REG_OUT=1 instance checks latency.
module tb_bram_1kb_access_driver;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  cfg_wr_width, cfg_rd_width;
    logic        req_valid, req_we, rsp_ready;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;

    logic        req_ready, rsp_valid, busy;
    logic [31:0] rsp_rdata, b_wr_data, b_rd_data;
    logic [7:0]  b_rd_addr, b_wr_addr;
    logic        c0, c1, c2, c3, c4, c5;

    logic        req_ready_1, rsp_valid_1, busy_1;
    logic [31:0] rsp_rdata_1, b1_wr_data, b1_rd_data;
    logic [7:0]  b1_rd_addr, b1_wr_addr;
    logic        d0, d1, d2, d3, d4, d5;

    bram_1kb_access_driver #(.REG_OUT(0)) dut (
        .clk(clk), .rst(rst), .cfg_wr_width(cfg_wr_width), .cfg_rd_width(cfg_rd_width),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .bram_rd_addr(b_rd_addr), .bram_wr_addr(b_wr_addr), .bram_wr_data(b_wr_data),
        .bram_rd_data(b_rd_data), .bram_c0(c0), .bram_c1(c1), .bram_c2(c2), .bram_c3(c3),
        .bram_c4(c4), .bram_c5(c5));

    bram_1kb_access_driver #(.REG_OUT(1)) dut_reg (
        .clk(clk), .rst(rst), .cfg_wr_width(cfg_wr_width), .cfg_rd_width(cfg_rd_width),
        .req_valid(req_valid), .req_ready(req_ready_1), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_1),
        .busy(busy_1), .bram_rd_addr(b1_rd_addr), .bram_wr_addr(b1_wr_addr), .bram_wr_data(b1_wr_data),
        .bram_rd_data(b1_rd_data), .bram_c0(d0), .bram_c1(d1), .bram_c2(d2), .bram_c3(d3),
        .bram_c4(d4), .bram_c5(d5));

    // RAM model: narrow reads return the sub-word in the low bits with junk above it.
    function automatic logic [31:0] ram_rd(input logic [31:0] w, input logic [1:0] sel, input logic [1:0] rc);
        if (rc == 2'b10)      return ((w >> (int'(sel) * 8)) & 32'h0000_00FF) | 32'hA5A5_A500;
        else if (rc == 2'b01) return ((w >> (int'(sel[0]) * 16)) & 32'h0000_FFFF) | 32'h5A5A_0000;
        else                  return w;
    endfunction

    logic [31:0] ram [256];
    logic [31:0] ram_q;
    logic [31:0] r1a, r1b;
    assign b_rd_data  = ram_q;
    assign b1_rd_data = r1b;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        ram_q = 32'd0; r1a = 32'd0; r1b = 32'd0;
    end

    always @(posedge clk) begin
        ram_q <= ram_rd(ram[b_rd_addr], b_wr_data[25:24], {c2, c3});
        if (b_wr_data[20]) begin
            if ({c0, c1} == 2'b10) ram[b_wr_addr][int'(b_wr_data[17:16]) * 8 +: 8] <= b_wr_data[7:0];
            else                   ram[b_wr_addr][int'(b_wr_data[16]) * 16 +: 16] <= b_wr_data[15:0];
        end
        r1a <= {8'hC3, 16'h0000, b1_rd_addr};
        r1b <= r1a;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: flat byte memory plus an ordered queue of expected responses.
    typedef struct { logic [31:0] d; int avail; } rsp_t;
    rsp_t        q[$];
    logic [7:0]  mb [1024];
    int          m_cyc = 0;
    logic [31:0] em_wd, md;
    logic [7:0]  em_wa, em_ra;
    logic [9:0]  bi;
    logic [1:0]  sel;
    logic        m_acc, m_pop, started;

    initial begin
        for (int i = 0; i < 1024; i++) mb[i] = 8'd0;
        em_wd = 32'd0; em_wa = 8'd0; em_ra = 8'd0;
        forever begin
            @(posedge clk);
            m_pop = (q.size() != 0) && (q[0].avail <= m_cyc) && rsp_ready;
            m_acc = req_valid && (q.size() < 4);
            m_cyc = m_cyc + 1;
            if (rst) begin
                q.delete();
                em_wd = 32'd0; em_wa = 8'd0; em_ra = 8'd0;
            end else begin
                em_wd = 32'd0;
                if (m_pop) void'(q.pop_front());
                if (m_acc && req_we) begin
                    em_wa = req_addr[7:0];
                    if (cfg_wr_width == 2'd1) begin
                        sel = req_addr[9:8];
                        mb[{req_addr[7:0], req_addr[9:8]}] = req_wdata[7:0];
                        em_wd = 32'h0010_0000 | (32'(sel) << 16) | {24'd0, req_wdata[7:0]};
                    end else begin
                        sel = {1'b0, req_addr[8]};
                        bi = {req_addr[7:0], req_addr[8], 1'b0};
                        mb[bi] = req_wdata[7:0];
                        mb[bi + 10'd1] = req_wdata[15:8];
                        em_wd = 32'h0010_0000 | (32'(sel) << 16) | {16'd0, req_wdata};
                    end
                end else if (m_acc) begin
                    em_ra = req_addr[7:0];
                    case (cfg_rd_width)
                        2'd2: begin
                            sel = req_addr[9:8];
                            md = {24'd0, mb[{req_addr[7:0], req_addr[9:8]}]};
                        end
                        2'd1: begin
                            sel = {1'b0, req_addr[8]};
                            bi = {req_addr[7:0], req_addr[8], 1'b0};
                            md = {16'd0, mb[bi + 10'd1], mb[bi]};
                        end
                        default: begin
                            sel = 2'd0;
                            bi = {req_addr[7:0], 2'd0};
                            md = {mb[bi + 10'd3], mb[bi + 10'd2], mb[bi + 10'd1], mb[bi]};
                        end
                    endcase
                    em_wd = 32'(sel) << 24;
                    q.push_back('{d: md, avail: m_cyc + 2});
                end
            end
        end
    end

    // Per-cycle comparison, sampled just after the falling edge.
    logic       ev;
    logic [5:0] ecfg;
    initial begin
        started = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (started) begin
                ev = (q.size() != 0) && (q[0].avail <= m_cyc);
                chk("req_ready", {31'd0, req_ready}, {31'd0, q.size() < 4});
                chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
                if (ev) chk("rsp_rdata", rsp_rdata, q[0].d);
                chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
                chk("bram_wr_data", b_wr_data, em_wd);
                chk("bram_wr_addr", {24'd0, b_wr_addr}, {24'd0, em_wa});
                chk("bram_rd_addr", {24'd0, b_rd_addr}, {24'd0, em_ra});
                ecfg[5:4] = (cfg_wr_width == 2'd1) ? 2'b10 : 2'b01;
                ecfg[3:2] = (cfg_rd_width == 2'd2) ? 2'b10 : (cfg_rd_width == 2'd1) ? 2'b01 : 2'b00;
                ecfg[1:0] = 2'b00;
                chk("cfg_pins", {26'd0, c0, c1, c2, c3, c4, c5}, {26'd0, ecfg});
            end
        end
    end

    task automatic req(input logic we, input logic [9:0] a, input logic [15:0] d);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_timeout", n, (n < 50) ? n : 0);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input logic [31:0] exp, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rsp_valid && rsp_ready) && n < 20);
        if (n >= 20) chk({name, "_timeout"}, 32'd1, 32'd0);
        else         chk(name, rsp_rdata, exp);
    endtask

    int lat0, lat1, acc;
    logic [9:0] bp_addr [4];

    initial begin
        rst = 1'b1; cfg_wr_width = 2'd1; cfg_rd_width = 2'd0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 10'd0; req_wdata = 16'd0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_data", b_wr_data, 32'd0);
        chk("rst_addrs", {16'd0, b_rd_addr, b_wr_addr}, 32'd0);
        started = 1'b1;

        // Read latency for both output-register settings.
        req(1'b0, 10'h005, 16'h0000);
        lat0 = 0; lat1 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (rsp_valid && lat0 == 0) begin
                lat0 = k;
                chk("lat0_data", rsp_rdata, 32'h0000_0000);
            end
            if (rsp_valid_1 && lat1 == 0) begin
                lat1 = k;
                chk("lat1_data", rsp_rdata_1, 32'hC300_0005);
            end
        end
        chk("latency_reg0", lat0, 3);
        chk("latency_reg1", lat1, 4);
        chk("c5_pins", {30'd0, c5, d5}, 32'd1);

        // Byte write with sub-word select 2.
        req(1'b1, 10'h2A5, 16'h003C);
        idle();
        chk("wr_addr_A5", {24'd0, b_wr_addr}, 32'h0000_00A5);
        chk("wr_data_pkt", b_wr_data, 32'h0012_003C);
        @(negedge clk);
        chk("wr_data_after", b_wr_data, 32'd0);

        // Four bytes into row 5, then word and byte reads.
        req(1'b1, 10'h005, 16'hFF11);
        req(1'b1, 10'h105, 16'hFF22);
        req(1'b1, 10'h205, 16'hFF33);
        req(1'b1, 10'h305, 16'hFF44);
        req(1'b0, 10'h005, 16'h0000);
        idle();
        get_rsp(32'h4433_2211, "rd32_row5");
        @(negedge clk);
        cfg_rd_width = 2'd2;
        req(1'b0, 10'h205, 16'h0000);
        idle();
        get_rsp(32'h0000_0033, "rd8_0x205");

        // Backpressure: six reads offered, four credits.
        bp_addr[0] = 10'h005; bp_addr[1] = 10'h105; bp_addr[2] = 10'h205; bp_addr[3] = 10'h305;
        @(negedge clk);
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_addr = bp_addr[i % 4];
            if (req_ready) acc++;
        end
        idle();
        chk("bp_accepted", acc, 4);
        repeat (3) @(negedge clk);
        chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
        chk("bp_head", rsp_rdata, 32'h0000_0011);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_after_pop", {31'd0, req_ready}, 32'd1);
        chk("bp_order1", rsp_rdata, 32'h0000_0022);
        @(negedge clk);
        chk("bp_order2", rsp_rdata, 32'h0000_0033);
        @(negedge clk);
        chk("bp_order3", rsp_rdata, 32'h0000_0044);
        @(negedge clk);
        chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

        // Halfword writes and read-after-write on the same row.
        cfg_wr_width = 2'd0; cfg_rd_width = 2'd1;
        req(1'b1, 10'h007, 16'h1234);
        req(1'b1, 10'h107, 16'hBEEF);
        req(1'b0, 10'h107, 16'h0000);
        req(1'b0, 10'h007, 16'h0000);
        idle();
        get_rsp(32'h0000_BEEF, "rd16_hi");
        get_rsp(32'h0000_1234, "rd16_lo");
        @(negedge clk);
        cfg_rd_width = 2'd0;
        req(1'b0, 10'h007, 16'h0000);
        idle();
        get_rsp(32'hBEEF_1234, "rd32_row7");

        // Reset with two reads in flight and one queued.
        @(negedge clk);
        rsp_ready = 1'b0;
        req(1'b0, 10'h005, 16'h0000);
        req(1'b0, 10'h007, 16'h0000);
        req(1'b0, 10'h0A5, 16'h0000);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        lat0 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) lat0++;
        end
        chk("no_stale_rsp", lat0, 0);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
